// File: rtl/ram_2d_loader_pkg.sv
// Shared types and default geometry for the 2-D RAM frame loader.
package ram_2d_pkg;

  localparam int DATA_WIDTH_DEF   = 8;
  localparam int ADDR_WIDTH_W_DEF = 5;
  localparam int ADDR_WIDTH_H_DEF = 5;
  localparam int COLS_DEF         = 5;
  localparam int ROWS_DEF         = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/ram_2d_loader_if.sv
// Stream-in / RAM-write-out bundle of the frame loader.
interface ram_2d_loader_if
  import ram_2d_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH_W = ADDR_WIDTH_W_DEF,
  parameter int ADDR_WIDTH_H = ADDR_WIDTH_H_DEF
) ();

  logic                    start;
  logic [DATA_WIDTH-1:0]   in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic                    we;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [ADDR_WIDTH_W-1:0] write_addr_1;
  logic [ADDR_WIDTH_H-1:0] write_addr_2;
  logic                    busy;
  logic                    frame_done;
  logic                    start_err;

  modport slave (
    input  start, in_data, in_valid,
    output in_ready, we, wr_data, write_addr_1, write_addr_2, busy, frame_done, start_err
  );

  modport master (
    output start, in_data, in_valid,
    input  in_ready, we, wr_data, write_addr_1, write_addr_2, busy, frame_done, start_err
  );

endinterface

// File: rtl/ram_2d_loader_wrap_counter.sv
// Modulo counter with synchronous clear; wrap flags the terminal count.
module wrap_counter #(
  parameter int MODULUS = 5,
  parameter int WIDTH   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  assign wrap  = (count_q == WIDTH'(MODULUS - 1));
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = wrap ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/ram_2d_loader.sv
// Loads one ROWS x COLS frame from a valid/ready stream into a 2-D addressed RAM,
// raster order, with a one-cycle registered write port.
module ram_2d_loader
  import ram_2d_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH_W = ADDR_WIDTH_W_DEF,
  parameter int ADDR_WIDTH_H = ADDR_WIDTH_H_DEF,
  parameter int COLS         = COLS_DEF,
  parameter int ROWS         = ROWS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  ram_2d_loader_if.slave   bus
);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH_W-1:0] col;
  logic [ADDR_WIDTH_H-1:0] row;
  logic                    col_wrap, row_wrap;
  logic                    xfer, clr;
  logic                    we_q;
  logic [DATA_WIDTH-1:0]   wr_data_q;
  logic [ADDR_WIDTH_W-1:0] addr_1_q;
  logic [ADDR_WIDTH_H-1:0] addr_2_q;
  logic                    start_err_q;

  // Ready is masked during rst so a same-cycle transfer can never be accepted.
  assign bus.in_ready = (state_q == FILL) && !rst;
  assign xfer         = bus.in_valid && bus.in_ready;
  assign clr          = (state_q == IDLE) && bus.start;

  wrap_counter #(.MODULUS(COLS), .WIDTH(ADDR_WIDTH_W)) u_col (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .inc   (xfer),
    .count (col),
    .wrap  (col_wrap)
  );

  wrap_counter #(.MODULUS(ROWS), .WIDTH(ADDR_WIDTH_H)) u_row (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .inc   (xfer && col_wrap),
    .count (row),
    .wrap  (row_wrap)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = FILL;
      FILL:    if (xfer && col_wrap && row_wrap) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q        <= 1'b0;
      wr_data_q   <= '0;
      addr_1_q    <= '0;
      addr_2_q    <= '0;
      start_err_q <= 1'b0;
    end else begin
      we_q <= xfer;
      if (xfer) begin
        wr_data_q <= bus.in_data;
        addr_1_q  <= col;
        addr_2_q  <= row;
      end
      if (bus.start && (state_q == FILL)) begin
        start_err_q <= 1'b1;
      end
    end
  end

  assign bus.we           = we_q;
  assign bus.wr_data      = wr_data_q;
  assign bus.write_addr_1 = addr_1_q;
  assign bus.write_addr_2 = addr_2_q;
  assign bus.busy         = (state_q == FILL);
  assign bus.frame_done   = (state_q == DONE);
  assign bus.start_err    = start_err_q;

endmodule

// File: tb/tb_ram_2d_loader.sv
// Scoreboard bench for ram_2d_loader: default 5x5 instance plus a 1x1 instance.
module tb_ram_2d_loader;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  ram_2d_loader_if ba ();
  ram_2d_loader_if bb ();

  ram_2d_loader dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ba)
  );

  ram_2d_loader #(.COLS(1), .ROWS(1)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bb)
  );

  typedef struct packed {
    logic [4:0] col;
    logic [4:0] row;
    logic [7:0] data;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   wr_a    = 0;
  int   wr_b    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // Monitors: every write pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (ba.we === 1'b1) begin
      exp_t e;
      wr_a++;
      if (qa.size() == 0) begin
        n_total++;
        $display("FAIL a_unexpected_write: got write col %0d row %0d data 0x%0h, expected none",
                 ba.write_addr_1, ba.write_addr_2, ba.wr_data);
      end else begin
        e = qa.pop_front();
        chk("a_col", 32'(ba.write_addr_1), 32'(e.col));
        chk("a_row", 32'(ba.write_addr_2), 32'(e.row));
        chk("a_data", 32'(ba.wr_data), 32'(e.data));
      end
    end
  end

  always @(negedge clk) begin
    if (bb.we === 1'b1) begin
      exp_t e;
      wr_b++;
      if (qb.size() == 0) begin
        n_total++;
        $display("FAIL b_unexpected_write: got write col %0d row %0d data 0x%0h, expected none",
                 bb.write_addr_1, bb.write_addr_2, bb.wr_data);
      end else begin
        e = qb.pop_front();
        chk("b_col", 32'(bb.write_addr_1), 32'(e.col));
        chk("b_row", 32'(bb.write_addr_2), 32'(e.row));
        chk("b_data", 32'(bb.wr_data), 32'(e.data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_we"},         32'(ba.we), 0);
    chk({tag, "_wr_data"},    32'(ba.wr_data), 0);
    chk({tag, "_addr1"},      32'(ba.write_addr_1), 0);
    chk({tag, "_addr2"},      32'(ba.write_addr_2), 0);
    chk({tag, "_busy"},       32'(ba.busy), 0);
    chk({tag, "_frame_done"}, 32'(ba.frame_done), 0);
    chk({tag, "_start_err"},  32'(ba.start_err), 0);
    chk({tag, "_in_ready"},   32'(ba.in_ready), 0);
  endtask

  task automatic do_start(input string tag);
    ba.start = 1'b1;
    tick();
    ba.start = 1'b0;
    chk({tag, "_in_ready"}, 32'(ba.in_ready), 1);
    chk({tag, "_busy"},     32'(ba.busy), 1);
  endtask

  task automatic push_a(input logic [7:0] d, input int k);
    exp_t e;
    e.col  = 5'(k % 5);
    e.row  = 5'(k / 5);
    e.data = d;
    ba.in_data  = d;
    ba.in_valid = 1'b1;
    qa.push_back(e);
    tick();
  endtask

  initial begin
    ba.start = 1'b0; ba.in_valid = 1'b0; ba.in_data = '0;
    bb.start = 1'b0; bb.in_valid = 1'b0; bb.in_data = '0;

    // Reset with start and valid asserted: reset must win.
    rst = 1'b1;
    ba.start = 1'b1; ba.in_valid = 1'b1; ba.in_data = 8'hEE;
    tick();
    tick();
    check_all_zero("rst");
    rst = 1'b0;
    ba.start = 1'b0; ba.in_valid = 1'b0;
    tick();
    chk("post_rst_busy", 32'(ba.busy), 0);

    // Back-to-back full frame; start during DONE is ignored.
    wr_a = 0;
    do_start("t36");
    for (int k = 0; k < 25; k++) push_a(8'(k), k);
    ba.in_valid = 1'b0;
    chk("t36_frame_done", 32'(ba.frame_done), 1);
    chk("t36_in_ready",   32'(ba.in_ready), 0);
    chk("t36_busy",       32'(ba.busy), 0);
    ba.start = 1'b1;
    tick();
    ba.start = 1'b0;
    chk("t36_frame_done_off", 32'(ba.frame_done), 0);
    chk("t36_done_start_busy", 32'(ba.busy), 0);
    chk("t36_done_start_err", 32'(ba.start_err), 0);
    chk("t36_in_ready_idle",  32'(ba.in_ready), 0);
    chk("t36_writes",         32'(wr_a), 25);

    // Alternating valid with garbage data on idle cycles.
    wr_a = 0;
    do_start("t37");
    for (int k = 0; k < 25; k++) begin
      push_a(8'(8'h40 + k), k);
      if (k < 24) begin
        ba.in_valid = 1'b0;
        ba.in_data  = 8'hFF;
        tick();
      end
    end
    ba.in_valid = 1'b0;
    chk("t37_frame_done", 32'(ba.frame_done), 1);
    tick();
    chk("t37_writes", 32'(wr_a), 25);
    chk("t37_frame_done_off", 32'(ba.frame_done), 0);

    // Start during FILL sets the sticky error but not the flow.
    wr_a = 0;
    chk("t38_err_init", 32'(ba.start_err), 0);
    do_start("t38");
    for (int k = 0; k < 25; k++) begin
      if (k == 2) ba.start = 1'b1;
      push_a(8'(8'h80 + k), k);
      ba.start = 1'b0;
      if (k == 2) begin
        chk("t38_err_set", 32'(ba.start_err), 1);
        chk("t38_busy_kept", 32'(ba.busy), 1);
      end
    end
    ba.in_valid = 1'b0;
    chk("t38_frame_done", 32'(ba.frame_done), 1);
    tick();
    chk("t38_err_held", 32'(ba.start_err), 1);
    chk("t38_idle", 32'(ba.busy), 0);
    do_start("t38b");
    for (int k = 0; k < 25; k++) push_a(8'(8'hA0 + k), k);
    ba.in_valid = 1'b0;
    chk("t38b_frame_done", 32'(ba.frame_done), 1);
    chk("t38b_err_held", 32'(ba.start_err), 1);
    tick();
    chk("t38_writes", 32'(wr_a), 50);

    // Reset mid-frame, colliding with a pending transfer.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t39_err_cleared", 32'(ba.start_err), 0);
    wr_a = 0;
    do_start("t39");
    for (int k = 0; k < 7; k++) push_a(8'(8'h10 + k), k);
    ba.in_data = 8'h77;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("t39");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t39_no_we", 32'(ba.we), 0);
    end
    chk("t39_writes", 32'(wr_a), 7);
    ba.in_valid = 1'b0;
    do_start("t39b");
    for (int k = 0; k < 25; k++) push_a(8'(8'h30 + k), k);
    ba.in_valid = 1'b0;
    chk("t39b_frame_done", 32'(ba.frame_done), 1);
    tick();

    // Valid without start: nothing happens.
    ba.in_valid = 1'b1;
    ba.in_data  = 8'h5A;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t40_in_ready", 32'(ba.in_ready), 0);
      chk("t40_we", 32'(ba.we), 0);
    end
    ba.in_valid = 1'b0;

    // 1x1 frame on the second instance.
    bb.start = 1'b1;
    tick();
    bb.start = 1'b0;
    chk("t41_in_ready", 32'(bb.in_ready), 1);
    begin
      exp_t e;
      e.col = 5'd0; e.row = 5'd0; e.data = 8'hA5;
      qb.push_back(e);
    end
    bb.in_data  = 8'hA5;
    bb.in_valid = 1'b1;
    tick();
    bb.in_valid = 1'b0;
    chk("t41_frame_done", 32'(bb.frame_done), 1);
    chk("t41_we", 32'(bb.we), 1);
    chk("t41_in_ready_off", 32'(bb.in_ready), 0);
    tick();
    chk("t41_frame_done_off", 32'(bb.frame_done), 0);
    chk("t41_busy", 32'(bb.busy), 0);
    chk("t41_writes", 32'(wr_b), 1);

    tick();
    chk("qa_drained", 32'(qa.size()), 0);
    chk("qb_drained", 32'(qb.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
